// File: rtl/oled_pkg.sv
// Shared types and command ROMs for the SSD1306 OLED controller.
package oled_pkg;

   typedef enum logic [3:0] {
      ST_OFF,
      ST_VDD_WAIT,
      ST_CMD_OFF,
      ST_RES_LOW,
      ST_RES_WAIT,
      ST_INIT1,
      ST_VBAT_WAIT,
      ST_INIT2,
      ST_READY,
      ST_SHUT,
      ST_SHUT_VBAT
   } state_t;

   localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;

   localparam int INIT1_LEN = 4;
   localparam int INIT2_LEN = 7;

   // Element 0 is the first byte on the wire.
   localparam logic [0:INIT1_LEN-1][7:0] INIT1_CMDS = {8'h8D, 8'h14, 8'hD9, 8'hF1};
   localparam logic [0:INIT2_LEN-1][7:0] INIT2_CMDS = {8'h81, 8'h0F, 8'hA0, 8'hC0,
                                                       8'hDA, 8'h00, 8'hAF};

endpackage

// File: rtl/oled_spi_ctrl_spi_byte_tx.sv
// SPI mode-3 byte shifter, MSB first; sclk idles high and sdin moves only on falling edges.
module spi_byte_tx #(
   parameter int CLK_DIV = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] byte_in,
   input  logic       dc_in,
   output logic       sclk,
   output logic       sdin,
   output logic       dc,
   output logic       busy,
   output logic       done
);

   localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);

   logic [15:0] cnt_r;
   logic [2:0]  bit_r;
   logic [7:0]  shreg_r;
   logic        sclk_r, sdin_r, dc_r, busy_r, done_r;

   // Half-period timer and bit sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= 16'd0;
         bit_r   <= 3'd0;
         shreg_r <= 8'h00;
         sclk_r  <= 1'b1;
         sdin_r  <= 1'b0;
         dc_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (!busy_r) begin
            if (start) begin
               busy_r  <= 1'b1;
               shreg_r <= byte_in;
               dc_r    <= dc_in;
               sdin_r  <= byte_in[7];
               sclk_r  <= 1'b0;
               bit_r   <= 3'd7;
               cnt_r   <= 16'd0;
            end
         end else if (cnt_r == HALF_LAST) begin
            cnt_r <= 16'd0;
            if (!sclk_r) begin
               sclk_r <= 1'b1;
            end else if (bit_r == 3'd0) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end else begin
               sclk_r <= 1'b0;
               sdin_r <= shreg_r[bit_r - 3'd1];
               bit_r  <= bit_r - 3'd1;
            end
         end else begin
            cnt_r <= cnt_r + 16'd1;
         end
      end
   end

   assign sclk = sclk_r;
   assign sdin = sdin_r;
   assign dc   = dc_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: rtl/oled_spi_ctrl.sv
// SSD1306 power/reset sequencer with an upstream byte stream and frame-boundary pulse.
module oled_spi_ctrl
   import oled_pkg::*;
#(
   parameter int CLK_DIV  = 5,
   parameter int VDD_DLY  = 100000,
   parameter int RES_DLY  = 300,
   parameter int VBAT_DLY = 10000000,
   parameter int PAGES    = 4,
   parameter int COLS     = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       power_on,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_dc,
   output logic       s_ready,
   output logic       panel_up,
   output logic       frame_done,
   output logic       sclk,
   output logic       sdin,
   output logic       dc,
   output logic       vdd,
   output logic       vbat,
   output logic       reset
);

   localparam logic [15:0] FRAME_LAST = 16'(PAGES * COLS - 1);

   state_t      state_r;
   logic [31:0] dly_r;
   logic [2:0]  idx_r;
   logic [15:0] fcnt_r;
   logic [7:0]  rom_byte_r;
   logic        start_r, s_ready_r, panel_up_r, frame_done_r, vdd_r, vbat_r, reset_r;
   logic        acc_s, eng_start_s, eng_dc_in_s, eng_dc_s, eng_busy_s, eng_done_s;
   logic [7:0]  eng_byte_s;

   // Upstream acceptance starts the engine in the same cycle; ROM bytes go out one cycle after issue.
   assign acc_s       = s_valid & s_ready_r;
   assign eng_start_s = start_r | acc_s;
   assign eng_byte_s  = acc_s ? s_data : rom_byte_r;
   assign eng_dc_in_s = acc_s ? s_dc : 1'b0;

   spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .start   (eng_start_s),
      .byte_in (eng_byte_s),
      .dc_in   (eng_dc_in_s),
      .sclk    (sclk),
      .sdin    (sdin),
      .dc      (eng_dc_s),
      .busy    (eng_busy_s),
      .done    (eng_done_s)
   );

   // Power sequencer, delay counter, ROM index and frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_OFF;
         dly_r        <= 32'd0;
         idx_r        <= 3'd0;
         fcnt_r       <= 16'd0;
         rom_byte_r   <= 8'h00;
         start_r      <= 1'b0;
         s_ready_r    <= 1'b0;
         panel_up_r   <= 1'b0;
         frame_done_r <= 1'b0;
         vdd_r        <= 1'b1;
         vbat_r       <= 1'b1;
         reset_r      <= 1'b1;
      end else begin
         start_r      <= 1'b0;
         frame_done_r <= 1'b0;
         if (eng_done_s && eng_dc_s) begin
            if (fcnt_r == FRAME_LAST) begin
               fcnt_r       <= 16'd0;
               frame_done_r <= 1'b1;
            end else begin
               fcnt_r <= fcnt_r + 16'd1;
            end
         end
         case (state_r)
            ST_OFF: begin
               if (power_on) begin
                  state_r <= ST_VDD_WAIT;
                  vdd_r   <= 1'b0;
                  dly_r   <= 32'(VDD_DLY - 1);
               end
            end
            ST_VDD_WAIT: begin
               if (dly_r == 32'd0) begin
                  state_r    <= ST_CMD_OFF;
                  start_r    <= 1'b1;
                  rom_byte_r <= CMD_DISPLAY_OFF;
               end else begin
                  dly_r <= dly_r - 32'd1;
               end
            end
            ST_CMD_OFF: begin
               if (eng_done_s) begin
                  state_r <= ST_RES_LOW;
                  reset_r <= 1'b0;
                  dly_r   <= 32'(RES_DLY - 1);
               end
            end
            ST_RES_LOW: begin
               if (dly_r == 32'd0) begin
                  state_r <= ST_RES_WAIT;
                  reset_r <= 1'b1;
                  dly_r   <= 32'(RES_DLY - 1);
               end else begin
                  dly_r <= dly_r - 32'd1;
               end
            end
            ST_RES_WAIT: begin
               if (dly_r == 32'd0) begin
                  state_r    <= ST_INIT1;
                  start_r    <= 1'b1;
                  rom_byte_r <= INIT1_CMDS[0];
                  idx_r      <= 3'd0;
               end else begin
                  dly_r <= dly_r - 32'd1;
               end
            end
            ST_INIT1: begin
               if (eng_done_s) begin
                  if (idx_r == 3'(INIT1_LEN - 1)) begin
                     state_r <= ST_VBAT_WAIT;
                     vbat_r  <= 1'b0;
                     dly_r   <= 32'(VBAT_DLY - 1);
                  end else begin
                     idx_r      <= idx_r + 3'd1;
                     start_r    <= 1'b1;
                     rom_byte_r <= INIT1_CMDS[idx_r[1:0] + 2'd1];
                  end
               end
            end
            ST_VBAT_WAIT: begin
               if (dly_r == 32'd0) begin
                  state_r    <= ST_INIT2;
                  start_r    <= 1'b1;
                  rom_byte_r <= INIT2_CMDS[0];
                  idx_r      <= 3'd0;
               end else begin
                  dly_r <= dly_r - 32'd1;
               end
            end
            ST_INIT2: begin
               if (eng_done_s) begin
                  if (idx_r == 3'(INIT2_LEN - 1)) begin
                     state_r    <= ST_READY;
                     panel_up_r <= 1'b1;
                  end else begin
                     idx_r      <= idx_r + 3'd1;
                     start_r    <= 1'b1;
                     rom_byte_r <= INIT2_CMDS[idx_r + 3'd1];
                  end
               end
            end
            ST_READY: begin
               // A byte in flight always finishes before shutdown begins.
               if (acc_s) begin
                  s_ready_r <= 1'b0;
               end else if (!eng_busy_s && !power_on) begin
                  state_r    <= ST_SHUT;
                  s_ready_r  <= 1'b0;
                  panel_up_r <= 1'b0;
                  start_r    <= 1'b1;
                  rom_byte_r <= CMD_DISPLAY_OFF;
               end else begin
                  s_ready_r <= ~eng_busy_s & power_on;
               end
            end
            ST_SHUT: begin
               if (eng_done_s) begin
                  state_r <= ST_SHUT_VBAT;
                  vbat_r  <= 1'b1;
                  dly_r   <= 32'(VBAT_DLY - 1);
               end
            end
            ST_SHUT_VBAT: begin
               if (dly_r == 32'd0) begin
                  state_r <= ST_OFF;
                  vdd_r   <= 1'b1;
                  fcnt_r  <= 16'd0;
               end else begin
                  dly_r <= dly_r - 32'd1;
               end
            end
            default: begin
               state_r <= ST_OFF;
            end
         endcase
      end
   end

   assign s_ready    = s_ready_r;
   assign panel_up   = panel_up_r;
   assign frame_done = frame_done_r;
   assign dc         = eng_dc_s;
   assign vdd        = vdd_r;
   assign vbat       = vbat_r;
   assign reset      = reset_r;

endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Scoreboard bench for oled_spi_ctrl: decodes sdin/dc at sclk rises and checks sequencing timing.
module tb_oled_spi_ctrl;

   localparam int CLK_DIV  = 2;
   localparam int VDD_DLY  = 10;
   localparam int RES_DLY  = 4;
   localparam int VBAT_DLY = 20;
   localparam int PAGES    = 2;
   localparam int COLS     = 4;
   localparam int FRAME    = PAGES * COLS;
   localparam int BYTE_CYC = 16 * CLK_DIV + 1;

   localparam int SEL_VDD   = 0;
   localparam int SEL_RESET = 1;
   localparam int SEL_VBAT  = 2;
   localparam int SEL_PANEL = 3;
   localparam int SEL_READY = 4;
   localparam int SEL_SCLK  = 5;

   logic       clk = 1'b0;
   logic       rst, power_on, s_valid, s_dc;
   logic [7:0] s_data;
   logic       s_ready, panel_up, frame_done, sclk, sdin, dc, vdd, vbat, reset;

   logic [8:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         fd_cnt   = 0;
   int         model_cnt = 0;

   oled_spi_ctrl #(
      .CLK_DIV(CLK_DIV), .VDD_DLY(VDD_DLY), .RES_DLY(RES_DLY),
      .VBAT_DLY(VBAT_DLY), .PAGES(PAGES), .COLS(COLS)
   ) dut (
      .clk(clk), .rst(rst), .power_on(power_on), .s_valid(s_valid), .s_data(s_data),
      .s_dc(s_dc), .s_ready(s_ready), .panel_up(panel_up), .frame_done(frame_done),
      .sclk(sclk), .sdin(sdin), .dc(dc), .vdd(vdd), .vbat(vbat), .reset(reset)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         SEL_VDD:   return vdd;
         SEL_RESET: return reset;
         SEL_VBAT:  return vbat;
         SEL_PANEL: return panel_up;
         SEL_READY: return s_ready;
         SEL_SCLK:  return sclk;
         default:   return 1'b0;
      endcase
   endfunction

   // n = number of rising clk edges until the selected output reads val
   task automatic wait_for(input int sel, input logic val, input int budget, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (sig(sel) !== val && n < budget);
      check_eq($sformatf("wait_sel%0d", sel), {31'd0, sig(sel)}, {31'd0, val});
   endtask

   task automatic push_init();
      logic [7:0] seq [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
                               8'h81, 8'h0F, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
      for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, seq[i]});
   endtask

   task automatic xfer(input logic [7:0] d, input logic c);
      int n;
      int fd0;
      int exp_fd;
      if (!s_ready) wait_for(SEL_READY, 1'b1, 200, n);
      s_data = d; s_dc = c; s_valid = 1'b1;
      exp_q.push_back({c, d});
      fd0 = fd_cnt;
      @(posedge clk); #1;
      s_valid = 1'b0;
      exp_fd = 0;
      if (c) begin
         model_cnt++;
         if (model_cnt == FRAME) begin
            exp_fd = 1;
            model_cnt = 0;
         end
      end
      wait_for(SEL_READY, 1'b1, 200, n);
      check_eq("byte_time", n, BYTE_CYC);
      @(negedge clk); #1;
      check_eq("frame_done", fd_cnt - fd0, exp_fd);
   endtask

   // Decode each byte at sclk rising edges and compare with the scoreboard.
   always @(negedge clk) begin : mon
      static int         nbits  = 0;
      static logic       sclk_q = 1'b1;
      static logic [7:0] shreg  = 8'h00;
      logic [8:0]        e;
      if (frame_done) fd_cnt++;
      if (rst) begin
         nbits  = 0;
         sclk_q = 1'b1;
      end else begin
         if (sclk && !sclk_q) begin
            shreg = {shreg[6:0], sdin};
            nbits++;
            if (nbits == 8) begin
               nbits = 0;
               if (exp_q.size() == 0) begin
                  check_eq("sb_extra", 32'd0, 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("sb_byte", {23'd0, dc, shreg}, {23'd0, e});
               end
            end
         end
         sclk_q = sclk;
      end
   end

   initial begin
      int n;
      rst = 1'b1; power_on = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_dc = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_outs", {sclk, sdin, dc, vdd, vbat, reset, s_ready, panel_up, frame_done},
               9'b100111000);

      // Power-up sequence
      push_init();
      rst = 1'b0;
      wait_for(SEL_VDD, 1'b0, 50, n);
      check_eq("vdd_lat", n, 1);
      wait_for(SEL_RESET, 1'b0, 200, n);
      check_eq("ae_sent", exp_q.size(), 11);
      wait_for(SEL_RESET, 1'b1, 50, n);
      check_eq("res_low", n, RES_DLY);
      // RES_WAIT, then one cycle to issue the first INIT1 byte
      wait_for(SEL_SCLK, 1'b0, 50, n);
      check_eq("res_high", n, RES_DLY + 1);
      wait_for(SEL_VBAT, 1'b0, 500, n);
      check_eq("init1_sent", exp_q.size(), 7);
      wait_for(SEL_SCLK, 1'b0, 100, n);
      check_eq("vbat_wait", n, VBAT_DLY + 1);
      wait_for(SEL_PANEL, 1'b1, 2000, n);
      check_eq("init2_sent", exp_q.size(), 0);

      // Single stream byte, then a frame with interleaved commands
      xfer(8'hA5, 1'b1);
      for (int i = 0; i < 17; i++)
         xfer(8'($urandom_range(0, 255)), (i == 3 || i == 9) ? 1'b0 : 1'b1);
      check_eq("stream_sb", exp_q.size(), 0);

      // Shutdown with a byte in flight
      s_data = 8'h3C; s_dc = 1'b1; s_valid = 1'b1;
      exp_q.push_back({1'b1, 8'h3C});
      exp_q.push_back({1'b0, 8'hAE});
      @(posedge clk); #1;
      s_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 power_on = 1'b0;
      wait_for(SEL_VBAT, 1'b1, 300, n);
      check_eq("shut_sb", exp_q.size(), 0);
      wait_for(SEL_VDD, 1'b1, 100, n);
      check_eq("vbat_to_vdd", n, VBAT_DLY);
      check_eq("off_outs", {panel_up, s_ready, reset, sclk}, 4'b0011);
      repeat (5) @(posedge clk);
      #1 check_eq("stay_off", {vdd, vbat}, 2'b11);

      // Re-power: frame counter must restart from zero
      power_on = 1'b1;
      push_init();
      wait_for(SEL_PANEL, 1'b1, 2000, n);
      check_eq("repower_sb", exp_q.size(), 0);
      model_cnt = 0;
      for (int i = 0; i < FRAME; i++) xfer(8'($urandom_range(0, 255)), 1'b1);

      // Asynchronous reset while sclk is low mid-byte
      s_data = 8'h96; s_dc = 1'b1; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      wait_for(SEL_SCLK, 1'b1, 20, n);
      wait_for(SEL_SCLK, 1'b0, 20, n);
      #2 rst = 1'b1;
      #1 check_eq("async_rst", {sclk, vdd, vbat, reset, s_ready, panel_up}, 6'b111100);
      exp_q.delete();
      repeat (3) @(negedge clk);
      check_eq("rst_hold", {sclk, dc, vdd, vbat}, 4'b1011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
